// File: rtl/seg_scan_driver_if.sv
// Load/display bundle for seg_scan_driver.
// master: the side that loads data and watches the display pins.
// slave: the scan driver itself.
interface seg_scan_driver_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic                    enable;
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_mask;
  logic                    ready;
  logic [N_DIGITS-1:0]     ss_digit;
  logic [6:0]              segment;
  logic                    dp;
  logic                    frame_tick;

  modport master (
    output enable, load, value, dp_mask,
    input  ready, ss_digit, segment, dp, frame_tick
  );

  modport slave (
    input  enable, load, value, dp_mask,
    output ready, ss_digit, segment, dp, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver.
// - A new value/dp_mask is loaded into a shadow register through a ready/load handshake.
// - The shadow register is copied to the displayed (active) register only at a frame wrap,
//   so a frame never mixes old and new digits.
// - Optional macro SEG_SCAN_LZ_BLANK_EN: blank leading zero digits (digit 0 is always shown).
module seg_scan_driver #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned PRESCALE = 100000
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic                  r_pend;
  logic [4*N_DIGITS-1:0] r_shadow_val;
  logic [N_DIGITS-1:0]   r_shadow_dp;
  logic [4*N_DIGITS-1:0] r_active_val;
  logic [N_DIGITS-1:0]   r_active_dp;
  logic [N_DIGITS-1:0]   r_ss;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_adv;
  logic                  w_wrap;
  logic                  w_accept;
  logic                  w_xfer;
  logic [3:0]            w_nibble;
  logic                  w_dp_bit;
  logic                  w_blank;
  logic [N_DIGITS-1:0]   w_ss_d;
  logic [N_DIGITS-1:0]   w_lz;
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic                  w_zero_run;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_adv    = (r_presc == PRESC_LAST);
  assign w_wrap   = w_adv && (r_idx == IDX_LAST);
  // Capture and transfer are mutually exclusive: capture needs no pending update,
  // transfer needs one. A load on the wrap edge therefore waits a full frame.
  assign w_accept = bus.load && !r_pend;
  assign w_xfer   = w_wrap && r_pend;

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_adv) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Load handshake into shadow; shadow to active at the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= 1'b0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
    end else if (w_xfer) begin
      r_active_val <= r_shadow_val;
      r_active_dp  <= r_shadow_dp;
      r_pend       <= 1'b0;
    end else if (w_accept) begin
      r_shadow_val <= bus.value;
      r_shadow_dp  <= bus.dp_mask;
      r_pend       <= 1'b1;
    end
  end

  // Leading-zero mask: w_lz[k] set when nibbles k..N_DIGITS-1 are all zero (k > 0).
  always_comb begin
    w_lz = '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
    w_zero_run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_active_val[4*k +: 4] == 4'h0);
      if (k > 0) begin
        w_lz[k] = w_zero_run;
      end
    end
`endif
  end

  // Select the nibble, dp bit and anode pattern for the current index.
  always_comb begin
    w_nibble = 4'h0;
    w_dp_bit = 1'b0;
    w_blank  = 1'b0;
    w_ss_d   = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nibble  = r_active_val[4*k +: 4];
        w_dp_bit  = r_active_dp[k];
        w_blank   = w_lz[k];
        w_ss_d[k] = 1'b0;
      end
    end
  end

  // Registered pin drive; enable only gates the pins, never the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss  <= '1;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (bus.enable) begin
      r_ss  <= w_ss_d;
      r_seg <= w_blank ? 7'b1111111 : hex7(w_nibble);
      r_dp  <= ~w_dp_bit;
    end else begin
      r_ss  <= '1;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end
  end

  assign bus.ready      = ~r_pend;
  assign bus.frame_tick = w_wrap;
  assign bus.ss_digit   = r_ss;
  assign bus.segment    = r_seg;
  assign bus.dp         = r_dp;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver; generalises the fixed 8-digit `ss_digit`/`segment` output of the ALU system to N digits.
- Accepts a packed hex value and decimal-point mask through a load handshake.
- Scans one digit at a time at a programmable rate.
- Updates displayed data only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between the ALU/result logic and the board's anode/cathode pins.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..16).
- PRESCALE, 100000, clk cycles each digit is held (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = display on; 0 = all digits blanked, scan keeps running.
- load  in  1  request to latch value/dp_mask; honoured only when ready=1.
- value  in  4*N_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
- dp_mask  in  N_DIGITS  bit k = 1 lights the decimal point of digit k.
- ready  out  1  1 = no update pending, load will be accepted.
- ss_digit  out  N_DIGITS  digit enables, active-low, one-hot-cold.
- segment  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when scan index wraps N_DIGITS-1 -> 0.

Behaviour:
- Reset values (asynchronous):
  - prescale counter 0, digit index 0.
  - shadow and active registers 0.
  - ready=1, frame_tick=0.
  - ss_digit all 1s, segment 7'b1111111, dp=1.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - At terminal count, wraps to 0 and digit index increments mod N_DIGITS.
  - PRESCALE=1 advances the index every cycle.
- frame_tick: high for exactly the one cycle in which index goes N_DIGITS-1 -> 0.
- Load handshake:
  - load=1 with ready=1 captures value/dp_mask into shadow and drives ready to 0 on the same edge.
  - load while ready=0 is ignored; shadow is unchanged.
- Frame-boundary update: on the wrap edge, if an update is pending, shadow -> active and ready returns to 1 on that edge.
- Load coincident with wrap: the new data is captured to shadow only; transfer happens on the following wrap, not the current one.
- Outputs:
  - Registered; they reflect the index and active data one cycle after the index changes.
  - First edge after reset release drives digit 0 from active (shows '0' with enable=1).
- Digit drive:
  - ss_digit[index]=0, all other bits 1.
  - segment = hex decode of active nibble[index].
  - dp = ~active_dp[index].
- enable=0: ss_digit all 1s, segment all 1s, dp=1; prescaler, index, handshake and frame_tick unaffected.
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-frame or with an update pending: everything returns to reset values immediately; pending data is discarded.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - Digit k > 0 is blanked (segment all 1s, dp still driven) when active nibbles k..N_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 displays a single '0'.
  - ss_digit scanning is unchanged.
- Undefined: all digits are always decoded, leading zeros shown.

Test Plan:
- Reset and first digit (N_DIGITS=4, PRESCALE=2): reset, release with enable=1.
  - During reset: ss_digit=1111, segment=1111111.
  - Next edge: ss_digit=1110, segment=1000000.
  - Index advances every 2 cycles; frame_tick pulses every 8 cycles.
- Load and frame-boundary update: load value=16'h3906 mid-frame.
  - ready drops next edge.
  - Digits keep showing 0 until the wrap.
  - From the next frame: digit0 segment=0000010, digit1=1000000, digit2=0010000, digit3=0110000.
  - ready=1 at the wrap.
- Handshake rules:
  - Second load of 16'hFFFF while ready=0 is ignored; display shows 3906.
  - Load coincident with the frame_tick wrap is applied one frame later.
- Blanking and dp:
  - enable=0 gives ss_digit=1111, segment=1111111, dp=1 while frame_tick keeps pulsing.
  - dp_mask=4'b0010 gives dp=0 only while ss_digit=1101.
- SEG_SCAN_LZ_BLANK_EN:
  - value=16'h0050: digits 3 and 2 show 1111111; digit1=0010010; digit0=1000000.
  - value=0: only digit0 lit. Without the macro, all four digits show 1000000.
- Reset mid-operation: assert rst_n=0 with an update pending at index 2.
  - Immediate reset values, ready=1.
  - After release, display shows 0000.
